// File: rtl/data_mem_serial_port.sv
// Serial master port to off-chip data memory (cmd, addr, wdata out; rdata in).
// Define DATA_MEM_PARITY_EN to add an even-parity beat after the data beats.
module data_mem_serial_port #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  req,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_sel,
  output logic                  mem_oe,
  output logic [LANES-1:0]      mem_out,
  input  logic [LANES-1:0]      mem_in
);

`ifdef DATA_MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int A    = ADDR_WIDTH / LANES;
  localparam int D    = DATA_WIDTH / LANES;
  localparam int SW   = ADDR_WIDTH + DATA_WIDTH;
  localparam int LAD  = (A > D) ? A : D;
  localparam int LMAX = (LAD > TURN_CYCLES) ? LAD : TURN_CYCLES;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  localparam logic [CW-1:0] A_LD = CW'(A - 1);
  localparam logic [CW-1:0] D_LD = CW'(D - 1);
  localparam logic [CW-1:0] T_LD = CW'(TURN_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_PAR,
    S_TURN,
    S_RDATA,
    S_RPAR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [SW-1:0]         sh_q, sh_d;
  logic                  par_q, par_d;
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic [DATA_WIDTH-1:0] rsh_in;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  sel_q, sel_d;
  logic                  oe_q, oe_d;
  logic [LANES-1:0]      out_q, out_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    sh_d    = sh_q;
    par_d   = par_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    sel_d   = 1'b0;
    oe_d    = 1'b0;
    out_d   = '0;
    valid_d = 1'b0;
    rsh_in  = (rsh_q << LANES) | DATA_WIDTH'(mem_in);

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_CMD;
          rw_d    = req_rw;
          sh_d    = {req_addr, req_wdata};
          par_d   = ^req_wdata;
        end
      end
      S_CMD: begin
        state_d = S_ADDR;
        cnt_d   = A_LD;
      end
      S_ADDR: begin
        if (cnt_q == '0) begin
          state_d = rw_q ? S_WDATA : S_TURN;
          cnt_d   = rw_q ? D_LD : T_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WDATA: begin
        if (cnt_q == '0) begin
          state_d = PAR_EN ? S_PAR : S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PAR: state_d = S_DONE;
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_RDATA;
          cnt_d   = D_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RDATA: begin
        rsh_d = rsh_in;
        if (cnt_q == '0) begin
          if (PAR_EN) begin
            state_d = S_RPAR;
          end else begin
            state_d = S_DONE;
            rdata_d = rsh_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RPAR: begin
        state_d = S_DONE;
        rdata_d = rsh_q;
        err_d   = (^rsh_q) ^ mem_in[0];
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins are registered, so decode them from the state being entered.
    unique case (state_d)
      S_CMD: begin
        sel_d = 1'b1;
        oe_d  = 1'b1;
        out_d = LANES'(rw_d);
      end
      S_ADDR, S_WDATA: begin
        sel_d = 1'b1;
        oe_d  = 1'b1;
        out_d = sh_q[SW-1 -: LANES];
        sh_d  = sh_q << LANES;
      end
      S_PAR: begin
        sel_d = 1'b1;
        oe_d  = 1'b1;
        out_d = LANES'(par_q);
      end
      S_TURN, S_RDATA, S_RPAR: sel_d = 1'b1;
      S_DONE: valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      rsh_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = PAR_EN & err_q;
  assign mem_sel   = sel_q;
  assign mem_oe    = oe_q;
  assign mem_out   = out_q;

endmodule

// File: tb/tb_data_mem_serial_port.sv
// Scoreboard bench for data_mem_serial_port with a pin-level memory model.
// Honours DATA_MEM_PARITY_EN like the design.
module tb_data_mem_serial_port;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int L  = 1;
  localparam int T  = 1;
  localparam int A  = AW / L;
  localparam int D  = DW / L;
`ifdef DATA_MEM_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_sel;
  logic          mem_oe;
  logic [L-1:0]  mem_out;
  logic [L-1:0]  mem_in = '0;

  always #5 clk = ~clk;

  data_mem_serial_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LANES      (L),
    .TURN_CYCLES(T)
  ) u_dut (
    .sys_clk  (clk),
    .sys_reset(rst_n),
    .req      (req),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ready    (ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mem_sel  (mem_sel),
    .mem_oe   (mem_oe),
    .mem_out  (mem_out),
    .mem_in   (mem_in)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [L:0]    exp_beats[$];
  int            exp_len[$];
  logic [DW:0]   exp_rsp[$];
  bit            cor_q[$];
  logic [DW-1:0] ref_mem[256];
  logic [DW-1:0] phys[256];
  logic [DW-1:0] last_rd = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none at %0t", nm, $time);
  endtask

  function automatic logic [L-1:0] grp(logic [63:0] v, int w, int i);
    return L'(v >> (w - L * (i + 1)));
  endfunction

  task automatic push_frame(bit rw, logic [AW-1:0] a,
                            logic [DW-1:0] d, bit c);
    exp_beats.push_back({1'b1, L'(rw)});
    for (int i = 0; i < A; i++) exp_beats.push_back({1'b1, grp(a, AW, i)});
    if (rw) begin
      for (int i = 0; i < D; i++) exp_beats.push_back({1'b1, grp(d, DW, i)});
      if (PE != 0) exp_beats.push_back({1'b1, L'(^d)});
      exp_len.push_back(1 + A + D + PE);
      ref_mem[a] = d;
      exp_rsp.push_back({1'b0, last_rd});
    end else begin
      for (int i = 0; i < T + D + PE; i++) exp_beats.push_back('0);
      exp_len.push_back(1 + A + T + D + PE);
      last_rd = ref_mem[a];
      exp_rsp.push_back({(PE != 0) && c, last_rd});
    end
    cor_q.push_back(c);
  endtask

  task automatic issue(bit rw, logic [AW-1:0] a, logic [DW-1:0] d, bit c);
    int n;
    n = 0;
    @(negedge clk);
    req = 1'b1;
    req_rw = rw;
    req_addr = a;
    req_wdata = d;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      fail("accept_timeout");
    end else begin
      push_frame(rw, a, d, c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    req = 1'b0;
    while ((exp_rsp.size() != 0 || exp_beats.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin : model
    int b;
    bit rw, cor, was_valid;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic [L:0] eb;
    logic [DW:0] e;
    b = 0;
    rw = 0;
    cor = 0;
    was_valid = 0;
    ma = '0;
    md = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b = 0;
        was_valid = 0;
        mem_in = '0;
        continue;
      end
      if (was_valid) chk("ready_after_done", ready, 1);
      was_valid = rsp_valid;
      if (rsp_valid) begin
        chk("ready_in_done", ready, 0);
        if (exp_rsp.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
          chk("rsp_err", rsp_err, e[DW]);
        end
      end
      mem_in = L'($urandom);
      if (mem_sel) begin
        if (b == 0) begin
          rw = mem_out[0];
          ma = '0;
          md = '0;
          cor = (cor_q.size() != 0) ? cor_q.pop_front() : 1'b0;
        end
        if (exp_beats.size() == 0) begin
          fail("extra_beat");
        end else begin
          eb = exp_beats.pop_front();
          chk("beat_oe", mem_oe, eb[L]);
          chk("beat_out", mem_out, eb[L-1:0]);
        end
        if (b >= 1 && b <= A) ma = (ma << L) | AW'(mem_out);
        if (rw) begin
          if (b > A && b <= A + D) md = (md << L) | DW'(mem_out);
        end else if (b >= 1 + A + T && b < 1 + A + T + D) begin
          mem_in = grp(phys[ma], DW, b - (1 + A + T));
        end else if (b == 1 + A + T + D) begin
          mem_in = L'((^phys[ma]) ^ cor);
        end
        b++;
      end else if (b > 0) begin
        if (exp_len.size() == 0) fail("extra_frame");
        else chk("frame_len", b, exp_len.pop_front());
        chk("done_after_frame", rsp_valid, 1);
        if (rw) phys[ma] = md;
        b = 0;
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      phys[i] = v;
      ref_mem[i] = v;
    end
    phys[8'h12] = 8'hB7;
    ref_mem[8'h12] = 8'hB7;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_sel", mem_sel, 0);
    chk("rst_oe", mem_oe, 0);
    chk("rst_out", mem_out, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", ready, 1);
      chk("idle_sel", mem_sel, 0);
      chk("idle_valid", rsp_valid, 0);
    end

    issue(1'b1, 8'hA5, 8'h3C, 1'b0);
    drain();
    issue(1'b0, 8'h12, 8'h00, 1'b0);
    drain();

    issue(1'b0, 8'h5A, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sel", mem_sel, 0);
    chk("abort_oe", mem_oe, 0);
    chk("abort_ready", ready, 1);
    chk("abort_rdata", rsp_rdata, 0);
    exp_beats.delete();
    exp_len.delete();
    exp_rsp.delete();
    cor_q.delete();
    last_rd = '0;
    req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_abort_valid", rsp_valid, 0);
    end
    issue(1'b1, 8'h33, 8'hC4, 1'b0);
    drain();

    issue(1'b1, 8'h07, 8'h07, 1'b0);
    drain();
    issue(1'b0, 8'h07, 8'h00, 1'b1);
    drain();

    issue(1'b1, 8'h80, 8'hE1, 1'b0);
    issue(1'b0, 8'h80, 8'h00, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        req = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
